// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: shared definitions for the multicycle ARM control unit.
// Holds the FSM state enum, ALU op codes, instruction Op classes,
// datapath source-mux encodings, condition codes, and condition evaluation.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXECR  = 4'd6,
        ST_EXECI  = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9
    } state_e;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_EOR   = 3'b100;
    localparam logic [2:0] ALU_PASSB = 3'b101;
    localparam logic [2:0] ALU_LSL   = 3'b110;

    // Instruction classes (Instr[27:26])
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing commands (Instr[24:21])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // Source-mux encodings
    localparam logic [1:0] SRCA_RD1      = 2'b00;
    localparam logic [1:0] SRCA_PC       = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT   = 2'b10;
    localparam logic [1:0] SRCB_RD2      = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] IMM_8         = 2'b00;
    localparam logic [1:0] IMM_12        = 2'b01;
    localparam logic [1:0] IMM_24        = 2'b10;

    // Condition codes (Instr[31:28])
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Per-field flag write requests raised by the execute states
    typedef struct packed {
        logic nz;
        logic c;
        logic v;
    } flag_req_t;

    // Evaluate a condition code against an NZCV vector; 1111 never executes.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic res;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/arm_mc_controller_if.sv
// arm_mc_controller_if: control bus between the multicycle controller
// (master) and the shared-memory datapath (slave).
interface arm_mc_controller_if #(
    parameter int ALUCTRL_W = 3
);
    logic [31:0]          Instr;
    logic [3:0]           ALUFlags;
    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 MemWrite;
    logic                 IRWrite;
    logic                 RegWrite;
    logic [1:0]           RegSrc;
    logic [1:0]           ImmSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ResultSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic [3:0]           Flags;
    logic [3:0]           State;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl, Flags, State
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl, Flags, State
    );
endinterface

// File: rtl/mc_condunit.sv
// mc_condunit: NZCV flag register plus condition evaluation. Flag write
// requests from the FSM only take effect when the condition passes.
module mc_condunit
    import arm_mc_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  flag_req_t flag_req,
    output logic [3:0] flags,
    output logic      cond_ex
);
    logic [3:0] flags_q;
    logic [3:0] flags_d;

    // Condition uses the architectural flag register, never the live ALU flags.
    assign cond_ex = cond_eval(cond, flags_q);
    assign flags   = flags_q;

    // Merge requested NZ / C / V fields from the ALU into the held flags.
    always_comb begin
        flags_d = flags_q;
        if (cond_ex) begin
            if (flag_req.nz) flags_d[3:2] = alu_flags[3:2];
            if (flag_req.c)  flags_d[1]   = alu_flags[1];
            if (flag_req.v)  flags_d[0]   = alu_flags[0];
        end
    end

    // Flag register, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) flags_q <= 4'b0000;
        else       flags_q <= flags_d;
    end
endmodule

// File: rtl/arm_mc_controller.sv
// arm_mc_controller: Moore FSM sequencing ARMv4-subset instructions over a
// shared-memory multicycle datapath. Optional feature macro ARM_MC_SHIFT_EN
// turns register-form MOV with a nonzero LSL amount into an LSL that also
// updates C; without it MOV is always PASSB and leaves C alone.
module arm_mc_controller
    import arm_mc_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input logic clk,
    input logic reset,
    arm_mc_controller_if.master bus
);
    state_e state_q;
    state_e state_d;

    // Instruction fields
    logic [1:0] op;
    logic [3:0] cmd;
    logic [3:0] cond;
    logic       imm_i;
    logic       s_bit;
    logic       rd_is_pc;

    assign op       = bus.Instr[27:26];
    assign imm_i    = bus.Instr[25];
    assign cmd      = bus.Instr[24:21];
    assign s_bit    = bus.Instr[20];     // doubles as L for memory ops
    assign rd_is_pc = (bus.Instr[15:12] == 4'hF);
    assign cond     = bus.Instr[31:28];

    logic shift_lsl;
`ifdef ARM_MC_SHIFT_EN
    // Only the register form carries a shift field; LSL #0 stays a plain MOV.
    assign shift_lsl = (cmd == CMD_MOV) & ~imm_i & (bus.Instr[6:5] == 2'b00)
                     & (bus.Instr[11:7] != 5'd0);
`else
    assign shift_lsl = 1'b0;
`endif

    logic [2:0] alu_dp;
    logic       cmd_ok;
    logic       no_write;
    logic       cv_write;

    // Data-processing command decode: ALU op, flag classes, result suppression.
    always_comb begin
        alu_dp   = ALU_ADD;
        cmd_ok   = 1'b1;
        no_write = 1'b0;
        cv_write = 1'b0;
        case (cmd)
            CMD_ADD: begin alu_dp = ALU_ADD; cv_write = 1'b1; end
            CMD_SUB: begin alu_dp = ALU_SUB; cv_write = 1'b1; end
            CMD_AND: alu_dp = ALU_AND;
            CMD_ORR: alu_dp = ALU_ORR;
            CMD_EOR: alu_dp = ALU_EOR;
            CMD_CMP: begin alu_dp = ALU_SUB; cv_write = 1'b1; no_write = 1'b1; end
            CMD_TST: begin alu_dp = ALU_AND; no_write = 1'b1; end
            CMD_MOV: alu_dp = shift_lsl ? ALU_LSL : ALU_PASSB;
            default: cmd_ok = 1'b0;
        endcase
    end

    logic      cond_ex;
    flag_req_t flag_req;
    logic [3:0] flags;

    mc_condunit u_condunit (
        .clk      (clk),
        .reset    (reset),
        .cond     (cond),
        .alu_flags(bus.ALUFlags),
        .flag_req (flag_req),
        .flags    (flags),
        .cond_ex  (cond_ex)
    );

    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_op;

    // Per-state control outputs and next-state selection.
    always_comb begin
        state_d    = ST_FETCH;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALU_ADD;
        flag_req   = '0;
        unique case (state_q)
            ST_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                state_d    = ST_DECODE;
            end
            ST_DECODE: begin
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_FOUR;
                case (op)
                    OP_DP:   state_d = cmd_ok ? (imm_i ? ST_EXECI : ST_EXECR) : ST_FETCH;
                    OP_MEM:  state_d = ST_MEMADR;
                    OP_BR:   state_d = ST_BRANCH;
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                alu_src_b = SRCB_EXTIMM;
                state_d   = s_bit ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                adr_src = 1'b1;
                state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = cond_ex;
            end
            ST_MEMWR: begin
                adr_src   = 1'b1;
                mem_write = cond_ex;
            end
            ST_EXECR, ST_EXECI: begin
                alu_src_b   = (state_q == ST_EXECI) ? SRCB_EXTIMM : SRCB_RD2;
                alu_op      = alu_dp;
                flag_req.nz = s_bit;
                flag_req.c  = s_bit & (cv_write | shift_lsl);
                flag_req.v  = s_bit & cv_write;
                state_d     = ST_ALUWB;
            end
            ST_ALUWB: begin
                if (cond_ex & ~no_write) begin
                    if (rd_is_pc) pc_write  = 1'b1;
                    else          reg_write = 1'b1;
                end
            end
            ST_BRANCH: begin
                alu_src_a  = SRCA_ALUOUT;
                alu_src_b  = SRCB_EXTIMM;
                result_src = RES_ALURESULT;
                pc_write   = cond_ex;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // State register; asynchronous reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    // Write strobes are forced low for as long as reset is held.
    assign bus.PCWrite    = pc_write  & ~reset;
    assign bus.IRWrite    = ir_write  & ~reset;
    assign bus.MemWrite   = mem_write & ~reset;
    assign bus.RegWrite   = reg_write & ~reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = ALUCTRL_W'(alu_op);
    assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};
    assign bus.ImmSrc     = (op == OP_BR) ? IMM_24 : ((op == OP_MEM) ? IMM_12 : IMM_8);
    assign bus.Flags      = flags;
    assign bus.State      = state_q;
endmodule

// File: tb/tb_arm_mc_controller.sv
// tb_arm_mc_controller: directed instruction sequence with per-cycle
// expected outputs pushed into a queue; a negedge monitor pops and compares.
module tb_arm_mc_controller;
    logic clk = 1'b0;
    logic reset;

    arm_mc_controller_if #(.ALUCTRL_W(3)) bus();

    arm_mc_controller #(.ALUCTRL_W(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Expected MOV results depend on the shift feature.
`ifdef ARM_MC_SHIFT_EN
    localparam logic [2:0] A_MOV = 3'b110;
    localparam logic [3:0] F_MOV = 4'b1010;
`else
    localparam logic [2:0] A_MOV = 3'b101;
    localparam logic [3:0] F_MOV = 4'b1000;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  cyc;
        logic [21:0] vec;   // {State, PCW,Adr,MemW,IRW,RegW, ResSrc, SrcA, SrcB, ALUCtl, NZCV}
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          push_cyc = 0;
    logic [31:0] cur_instr = 32'h0;
    logic [21:0] act_vec;

    assign act_vec = {bus.State, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                      bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                      bus.ALUControl, bus.Flags};

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got st=%0d ctl=%b res=%b a=%b b=%b alu=%b nzcv=%b, expected st=%0d ctl=%b res=%b a=%b b=%b alu=%b nzcv=%b",
                     name, act[21:18], act[17:13], act[12:11], act[10:9], act[8:7], act[6:4], act[3:0],
                     req[21:18], req[17:13], req[12:11], req[10:9], req[8:7], req[6:4], req[3:0]);
        end else begin
            $display("ok   %s: st=%0d ctl=%b nzcv=%b", name, act[21:18], act[17:13], act[3:0]);
        end
    endtask

    // Monitor: one expected record per cycle while the queue holds any.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("instr %h cyc %0d", e.instr, e.cyc), act_vec, e.vec);
        end
    end

    task automatic ex(input logic [3:0] st, input logic [4:0] ctl, input logic [1:0] rs,
                      input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] alu,
                      input logic [3:0] fl);
        exp_t e;
        e.instr = cur_instr;
        e.cyc   = push_cyc[3:0];
        e.vec   = {st, ctl, rs, sa, sb, alu, fl};
        push_cyc++;
        exp_q.push_back(e);
    endtask

    task automatic fetch(input logic [3:0] fl);
        ex(4'd0, 5'b10010, 2'b10, 2'b01, 2'b10, 3'b000, fl);
    endtask

    task automatic decode(input logic [3:0] fl);
        ex(4'd1, 5'b00000, 2'b00, 2'b01, 2'b10, 3'b000, fl);
    endtask

    task automatic begin_instr(input logic [31:0] ins);
        cur_instr = ins;
        push_cyc  = 0;
    endtask

    task automatic run(input logic [3:0] af, input int n);
        bus.Instr    = cur_instr;
        bus.ALUFlags = af;
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam logic [21:0] RESET_VEC = {4'd0, 5'b00000, 2'b10, 2'b01, 2'b10, 3'b000, 4'b0000};

    initial begin
        reset        = 1'b1;
        bus.Instr    = 32'h0;
        bus.ALUFlags = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        begin_instr(32'h0);
        ex(4'd0, 5'b00000, 2'b10, 2'b01, 2'b10, 3'b000, 4'b0000);  // held in reset
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ADD R1,R0,#5
        begin_instr(32'hE2801005);
        fetch(4'b0000); decode(4'b0000);
        ex(4'd7, 5'b00000, 2'b00, 2'b00, 2'b01, 3'b000, 4'b0000);
        ex(4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000);
        run(4'b0000, 4);

        // SUBS R2,R1,#5 (R1=5) -> Z,C
        begin_instr(32'hE2512005);
        fetch(4'b0000); decode(4'b0000);
        ex(4'd7, 5'b00000, 2'b00, 2'b00, 2'b01, 3'b001, 4'b0000);
        ex(4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0110);
        run(4'b0110, 4);

        // BEQ +2, taken
        begin_instr(32'h0A000002);
        fetch(4'b0110); decode(4'b0110);
        ex(4'd9, 5'b10000, 2'b10, 2'b10, 2'b01, 3'b000, 4'b0110);
        run(4'b0000, 3);

        // CMP R1,#7 (R1=5) -> N, no borrow-free carry
        begin_instr(32'hE3510007);
        fetch(4'b0110); decode(4'b0110);
        ex(4'd7, 5'b00000, 2'b00, 2'b00, 2'b01, 3'b001, 4'b0110);
        ex(4'd8, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b1000);
        run(4'b1000, 4);

        // TST R1,#0 -> Z set, C/V from ALU ignored
        begin_instr(32'hE3110000);
        fetch(4'b1000); decode(4'b1000);
        ex(4'd7, 5'b00000, 2'b00, 2'b00, 2'b01, 3'b010, 4'b1000);
        ex(4'd8, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0100);
        run(4'b0111, 4);

        // BNE +2 with Z=1: not taken
        begin_instr(32'h1A000002);
        fetch(4'b0100); decode(4'b0100);
        ex(4'd9, 5'b00000, 2'b10, 2'b10, 2'b01, 3'b000, 4'b0100);
        run(4'b1111, 3);

        // ADDNES R1,R1,R2 with Z=1: no write, flags held
        begin_instr(32'h10911002);
        fetch(4'b0100); decode(4'b0100);
        ex(4'd6, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0100);
        ex(4'd8, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0100);
        run(4'b1001, 4);

        // LDR R3,[R0,#100]
        begin_instr(32'hE5903064);
        fetch(4'b0100); decode(4'b0100);
        ex(4'd2, 5'b00000, 2'b00, 2'b00, 2'b01, 3'b000, 4'b0100);
        ex(4'd3, 5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0100);
        ex(4'd4, 5'b00001, 2'b01, 2'b00, 2'b00, 3'b000, 4'b0100);
        run(4'b1111, 5);

        // STR R3,[R0,#104]
        begin_instr(32'hE5803068);
        fetch(4'b0100); decode(4'b0100);
        ex(4'd2, 5'b00000, 2'b00, 2'b00, 2'b01, 3'b000, 4'b0100);
        ex(4'd5, 5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0100);
        run(4'b1111, 4);

        // EOR R6,R1,R2
        begin_instr(32'hE0216002);
        fetch(4'b0100); decode(4'b0100);
        ex(4'd6, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b100, 4'b0100);
        ex(4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0100);
        run(4'b1111, 4);

        // ADD R15,R1,R2: write goes to PC
        begin_instr(32'hE081F002);
        fetch(4'b0100); decode(4'b0100);
        ex(4'd6, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0100);
        ex(4'd8, 5'b10000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0100);
        run(4'b0000, 4);

        // RSB (unsupported): back to FETCH after DECODE
        begin_instr(32'hE0616002);
        fetch(4'b0100); decode(4'b0100);
        run(4'b1111, 2);

        // MOVS R4,R5,LSL #3
        begin_instr(32'hE1B04185);
        fetch(4'b0100); decode(4'b0100);
        ex(4'd6, 5'b00000, 2'b00, 2'b00, 2'b00, A_MOV, 4'b0100);
        ex(4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, F_MOV);
        run(4'b1011, 4);

        // STR interrupted by reset in MEMWR
        begin_instr(32'hE5803068);
        fetch(F_MOV); decode(F_MOV);
        ex(4'd2, 5'b00000, 2'b00, 2'b00, 2'b01, 3'b000, F_MOV);
        run(4'b1111, 3);
        ex(4'd5, 5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, F_MOV);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("reset_abort_immediate", act_vec, RESET_VEC);
        ex(4'd0, 5'b00000, 2'b10, 2'b01, 2'b10, 3'b000, 4'b0000);
        @(negedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ADD R1,R0,#5 after recovery
        begin_instr(32'hE2801005);
        fetch(4'b0000); decode(4'b0000);
        ex(4'd7, 5'b00000, 2'b00, 2'b00, 2'b01, 3'b000, 4'b0000);
        ex(4'd8, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000);
        run(4'b1111, 4);

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: %0d records left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/arm_mc_controller.md
# arm_mc_controller

Multicycle control unit for the ARMv4-subset core. It sequences each instruction over 3–5 clocks through a Moore state machine and owns the NZCV flag register. It drives a shared-memory multicycle datapath: one memory port, instruction register, and registered ALU output. It extends the instruction set with EOR, CMP, TST, MOV and, optionally, LSL.

## Interface
- ALUCTRL_W, 3: ALUControl width; must be ≥3.
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- Instr  in  32  instruction register contents (IR output)
- ALUFlags  in  4  {N,Z,C,V} from ALU, valid in execute/memadr cycles
- PCWrite  out  1  load PC
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  load instruction register
- RegWrite  out  1  register-file write (third port)
- RegSrc  out  2  [0] RA1 = R15, [1] RA2 = Rd
- ImmSrc  out  2  00 imm8, 01 imm12, 10 branch imm24
- ALUSrcA  out  2  00 RD1, 01 PC, 10 ALUOut
- ALUSrcB  out  2  00 RD2, 01 ExtImm, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUControl  out  ALUCTRL_W  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 PASSB, 110 LSL
- Flags  out  4  current NZCV register
- State  out  4  current state encoding, for debug

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ADD (forms PC+8), RegSrc from Op.
  - Op=00 with I=1 → EXECI; Op=00 with I=0 → EXECR.
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=11 or an unsupported funct → FETCH, with no writes.
- MEMADR: RD1+imm12, ADD. L=1 → MEMRD; L=0 → MEMWR.
- MEMRD: AdrSrc=1 → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx → FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondEx → FETCH.
- EXECR / EXECI: ALUControl decoded from Funct[4:1]:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1010 CMP (SUB), 1000 TST (AND), 1101 MOV (PASSB, or LSL when the shift feature applies).
  - Next state is ALUWB.
- ALUWB: ResultSrc=00. RegWrite=CondEx & ~NoWrite, where NoWrite=1 for CMP/TST. If Rd=15 and the write occurs, PCWrite=1 and RegWrite=0.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ImmSrc=10, ADD, ResultSrc=10, PCWrite=CondEx → FETCH.
- Flag update happens at the clock edge ending EXECR/EXECI, gated by S=1 and CondEx:
  - N and Z are always written.
  - C and V are written only for ADD, SUB and CMP.
  - For logic ops and MOV, C/V keep their prior values.
- CondEx is evaluated from the Flags register, not from ALUFlags, using the standard 15-entry cond table. Cond=1111 gives CondEx=0.
- Non-DP states drive ADD and never update flags.
- Outputs are a pure function of State, Instr and Flags; there are no registered outputs besides State and Flags.

## Timing
- Reset: State=FETCH, Flags=0000, all write strobes 0. Reset asserted mid-instruction aborts it; no pending write completes.
- Latency per instruction: LDR 5, STR 4, DP 4, B 3 cycles. A failed condition costs the same cycles with no writes.
- IR is stable from DECODE onward. Instr is sampled combinationally in every state after FETCH.
- The first FETCH after reset release occurs on the first rising edge with reset low.

## Configuration
- ARM_MC_SHIFT_EN defined:
  - MOV with Instr[6:5]=00 and Instr[11:7]≠0 drives LSL; shamt is supplied by the datapath from Instr[11:7].
  - C is updated from the last bit shifted out when S=1.
- Undefined: funct 1101 always drives PASSB, shift fields are ignored, and C is never updated by MOV.

## Structure
- Shared package arm_mc_pkg holds:
  - state enum (4-bit), ALU op localparams, Op codes (DP/MEM/BR);
  - src-mux encodings, cond codes.
- Sub-module mc_condunit holds the flag register, cond evaluation, and the FlagWrite/CondEx gating. The FSM and decode stay in the top module.

## Test plan
- Reset, then ADD R1,R0,#5 with R0=0 → states FETCH, DECODE, EXECI, ALUWB; RegWrite=1 in cycle 4 only; PCWrite in FETCH.
- SUBS R2,R1,#5 with R1=5, then BEQ +2 → Flags=0110 after the SUBS execute; BRANCH asserts PCWrite=1.
- CMP R1,#7 (R1=5) → Flags N=1, C=0; RegWrite=0 in ALUWB.
- LDR R3,[R0,#100] → 5 cycles; AdrSrc=1 in MEMRD; RegWrite/ResultSrc=01 in MEMWB. STR takes 4 cycles with MemWrite only in MEMWR.
- ADDNE with Z=1 → no RegWrite, Flags unchanged, returns to FETCH after 4 cycles. Reset asserted in MEMWR → MemWrite drops immediately and State=FETCH.
- With ARM_MC_SHIFT_EN, MOVS R4,R5,LSL #3 → ALUControl=110 and C updated. Without the macro → ALUControl=101 and C held.
